// File: rtl/jesd204_up_sysref_multi_if.sv
// Up-domain register bus shared by the JESD204 register blocks.
// Writes are one-cycle strobes and are always accepted; reads have no strobe, up_rdata returns the word at the previous cycle's up_raddr.
interface jesd204_up_sysref_multi_if;
    logic [11:0] up_raddr;
    logic [31:0] up_rdata;
    logic        up_wreq;
    logic [11:0] up_waddr;
    logic [31:0] up_wdata;

    modport master (
        output up_raddr,
        output up_wreq,
        output up_waddr,
        output up_wdata,
        input  up_rdata
    );

    modport slave (
        input  up_raddr,
        input  up_wreq,
        input  up_waddr,
        input  up_wdata,
        output up_rdata
    );
endinterface

// File: rtl/jesd204_up_sysref_multi.sv
// Per-link SYSREF configuration, sticky status, saturating event counters and
// oneshot arm/capture FSM for NUM_LINKS links in the up_clk register domain.
module jesd204_up_sysref_multi #(
    parameter int          NUM_LINKS         = 2,
    parameter int          LMFC_OFFSET_WIDTH = 8,
    parameter int          CNT_WIDTH         = 16,
    parameter logic [11:0] BASE_ADDR         = 12'h040
) (
    input  logic                                   up_clk,
    input  logic                                   up_rstn,
    jesd204_up_sysref_multi_if.slave               up_bus,
    input  logic                                   up_cfg_is_writeable,
    input  logic [NUM_LINKS-1:0]                   up_event_sysref_edge,
    input  logic [NUM_LINKS-1:0]                   up_event_sysref_alignment_error,
    output logic [NUM_LINKS-1:0]                   up_cfg_sysref_oneshot,
    output logic [NUM_LINKS-1:0]                   up_cfg_sysref_disable,
    output logic [NUM_LINKS*LMFC_OFFSET_WIDTH-1:0] up_cfg_lmfc_offset,
    output logic [NUM_LINKS-1:0]                   up_sysref_armed,
    output logic [NUM_LINKS*2-1:0]                 up_sysref_state
);
    localparam int W = LMFC_OFFSET_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CAPTURED = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 clr,
        input logic                 ev
    );
        logic [CNT_WIDTH-1:0] base;
        base = clr ? '0 : cur;
        cnt_next = (ev && (base != CNT_MAX)) ? base + CNT_WIDTH'(1) : base;
    endfunction

    logic [31:0] rd_word [NUM_LINKS][4];
    logic [31:0] rdata_nxt;

    genvar n;
    generate
        for (n = 0; n < NUM_LINKS; n++) begin : g_link
            localparam logic [11:0] ADDR = BASE_ADDR + 12'(4 * n);

            logic                 wr_cfg, wr_lmfc, wr_status, wr_count;
            logic                 ev_edge, ev_err, arm_req;
            logic [1:0]           clr_mask;
            logic                 oneshot, cfg_disable, armed;
            logic [W-1:0]         lmfc;
            logic [1:0]           sticky;
            logic [CNT_WIDTH-1:0] edge_cnt, err_cnt;
            state_t               state;

            assign wr_cfg    = up_bus.up_wreq && up_cfg_is_writeable && (up_bus.up_waddr == ADDR);
            assign wr_lmfc   = up_bus.up_wreq && up_cfg_is_writeable && (up_bus.up_waddr == ADDR + 12'd1);
            assign wr_status = up_bus.up_wreq && (up_bus.up_waddr == ADDR + 12'd2);
            assign wr_count  = up_bus.up_wreq && (up_bus.up_waddr == ADDR + 12'd3);
            assign ev_edge   = up_event_sysref_edge[n];
            assign ev_err    = up_event_sysref_alignment_error[n];
            assign arm_req   = wr_status && up_bus.up_wdata[4];
            assign clr_mask  = wr_status ? up_bus.up_wdata[1:0] : 2'b00;

            always_ff @(posedge up_clk or negedge up_rstn) begin
                if (!up_rstn) begin
                    oneshot     <= 1'b0;
                    cfg_disable <= 1'b0;
                    lmfc        <= '0;
                    sticky      <= 2'b00;
                    edge_cnt    <= '0;
                    err_cnt     <= '0;
                end else begin
                    if (wr_cfg) begin
                        oneshot     <= up_bus.up_wdata[1];
                        cfg_disable <= up_bus.up_wdata[0];
                    end
                    if (wr_lmfc) begin
                        lmfc <= up_bus.up_wdata[W+1:2];
                    end
                    // An event arriving with its own clear keeps the bit set.
                    sticky   <= (sticky & ~clr_mask) | {ev_err, ev_edge};
                    edge_cnt <= cnt_next(edge_cnt, wr_count, ev_edge);
                    err_cnt  <= cnt_next(err_cnt, wr_count, ev_err);
                end
            end

            // Oneshot FSM; config gating uses the registered config, so a
            // config write takes effect on the FSM one cycle later.
            always_ff @(posedge up_clk or negedge up_rstn) begin
                if (!up_rstn) begin
                    state <= ST_IDLE;
                    armed <= 1'b0;
                end else if (!oneshot || cfg_disable) begin
                    state <= ST_IDLE;
                    armed <= 1'b0;
                end else begin
                    case (state)
                        ST_IDLE, ST_CAPTURED: begin
                            if (arm_req) begin
                                state <= ST_ARMED;
                                armed <= 1'b1;
                            end
                        end
                        ST_ARMED: begin
                            if (ev_edge) begin
                                state <= ST_CAPTURED;
                                armed <= 1'b0;
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                            armed <= 1'b0;
                        end
                    endcase
                end
            end

            assign up_cfg_sysref_oneshot[n]    = oneshot;
            assign up_cfg_sysref_disable[n]    = cfg_disable;
            assign up_cfg_lmfc_offset[n*W +: W] = lmfc;
            assign up_sysref_armed[n]          = armed;
            assign up_sysref_state[2*n +: 2]   = state;

            assign rd_word[n][0] = {30'd0, oneshot, cfg_disable};
            assign rd_word[n][1] = 32'({lmfc, 2'b00});
            assign rd_word[n][2] = {26'd0, state, 2'b00, sticky};
            assign rd_word[n][3] = {16'(err_cnt), 16'(edge_cnt)};
        end
    endgenerate

    always_comb begin
        rdata_nxt = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            for (int r = 0; r < 4; r++) begin
                if (up_bus.up_raddr == BASE_ADDR + 12'(4 * i + r)) begin
                    rdata_nxt = rd_word[i][r];
                end
            end
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_bus.up_rdata <= '0;
        end else begin
            up_bus.up_rdata <= rdata_nxt;
        end
    end
endmodule

// File: doc/jesd204_up_sysref_multi.md
Name: jesd204_up_sysref_multi

Overview:
Multi-link successor to the single-link SYSREF register block. It exposes per-link SYSREF configuration, sticky status, saturating event counters and a oneshot arm/capture state machine. It sits in the AXI JESD204 up-domain register map and is instantiated once for NUM_LINKS links. Event inputs arrive already synchronised to up_clk, and CDC happens upstream.

Parameters:
NUM_LINKS, 2, number of independent links (1..8)
LMFC_OFFSET_WIDTH, 8, LMFC offset field width (8..10)
CNT_WIDTH, 16, event counter width (1..16)
BASE_ADDR, 12'h040, word address of link 0 register 0; link n occupies BASE_ADDR+4n .. BASE_ADDR+4n+3

Ports:
up_clk  in  1  register clock; the only clock
up_rstn  in  1  reset; asynchronous assert, active-low
up_raddr  in  12  read word address
up_rdata  out  32  read data, registered
up_wreq  in  1  write strobe, one cycle
up_waddr  in  12  write word address
up_wdata  in  32  write data
up_cfg_is_writeable  in  1  gates configuration writes
up_event_sysref_edge  in  NUM_LINKS  per-link 1-cycle pulse, SYSREF edge seen
up_event_sysref_alignment_error  in  NUM_LINKS  per-link 1-cycle pulse, alignment error
up_cfg_sysref_oneshot  out  NUM_LINKS  per-link oneshot mode
up_cfg_sysref_disable  out  NUM_LINKS  per-link SYSREF disable
up_cfg_lmfc_offset  out  NUM_LINKS*LMFC_OFFSET_WIDTH  per-link offset; link n at [n*W +: W]
up_sysref_armed  out  NUM_LINKS  per-link oneshot armed (state ARMED)

Behaviour:
- Reset: up_rstn=0 asynchronously clears every register. Outputs: up_rdata=0, oneshot=0, disable=0, lmfc_offset=0, armed=0. Status=0, counters=0, all FSMs in IDLE. Reset mid-operation discards pending arm/capture.
- Register map for link n, where A = BASE_ADDR + 4n:
  - A+0 CONFIG: [1] oneshot, [0] disable, rest read 0. Written only when up_wreq && up_cfg_is_writeable.
  - A+1 LMFC: offset stored from and read at up_wdata[W+1:2]; bits [1:0] read 0. Gated by up_cfg_is_writeable.
  - A+2 STATUS: [5:4] FSM state (0 IDLE, 1 ARMED, 2 CAPTURED); [1] alignment error sticky; [0] edge sticky.
    - Write [1:0] is W1C.
    - Write [4]=1 is an arm request.
    - Not gated by up_cfg_is_writeable.
  - A+3 COUNT: [31:16] error count, [15:0] edge count, zero-extended from CNT_WIDTH. Any write clears both counters and is not gated.
- Addresses outside BASE_ADDR .. BASE_ADDR+4*NUM_LINKS-1 read 0; writes there are ignored.
- Read latency: up_rdata is registered from up_raddr every cycle, giving 1-cycle latency with no read strobe.
- Sticky status: next = (cur & ~clr) | event. An event in the same cycle as its clear wins, so the bit stays 1.
- Counters:
  - +1 per event pulse, saturating at 2^CNT_WIDTH-1 with no wrap.
  - Clear and event in the same cycle gives a result of 1.
- Oneshot FSM per link:
  - IDLE -> ARMED on arm request while oneshot=1 and disable=0. An arm request otherwise is ignored.
  - ARMED -> CAPTURED on an edge event.
  - CAPTURED -> ARMED on a new arm request.
  - Any state -> IDLE when oneshot=0 or disable=1, evaluated on the registered config values.
  - The edge event that captures also sets the sticky bit and increments the counter.
- up_sysref_armed[n] = (state==ARMED), registered; it updates the cycle after the transition condition.
- Links are fully independent; simultaneous events on all links are all recorded.

Test Plan:
- Reset: drive up_rstn low mid-traffic -> all outputs 0 immediately; read BASE_ADDR+2 after release -> 0.
- Config gating: write CONFIG link1 = 0x3 with writeable=0 -> reads 0. Repeat with writeable=1 -> up_cfg_sysref_oneshot[1]=1, disable[1]=1, read returns 0x3 one cycle after raddr.
- LMFC: W=10, write link0 LMFC = 0xFFC -> up_cfg_lmfc_offset[9:0]=0x3FF, readback 0xFFC.
- Sticky vs clear: edge pulse on link0 in the same cycle as W1C 0x1 -> bit0 stays 1. A later W1C with no event -> bit0 = 0.
- Counter saturation, CNT_WIDTH=4: 20 error pulses -> COUNT[31:16] = 0xF. Write COUNT with a simultaneous edge -> edge=1, error=0.
- Oneshot FSM:
  - oneshot=1, arm -> armed=1, state=1.
  - Edge -> armed=0, state=2.
  - Arm with disable=1 -> remains IDLE/ignored.
  - Clearing oneshot in ARMED -> IDLE.
